// File: rtl/mbscore_mem_port.sv
`default_nettype none
// ============================================================================
//  Module   : mbscore_mem_port
//  Purpose  : Core-to-bus memory port. Accepts one load/store at a time,
//             screens misalignment, and waits for the bus ack with a timeout.
//  Revision : 1.0  initial release
// ============================================================================
module mbscore_mem_port #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    // core side
    input  logic                    i_req_valid,
    input  logic                    i_req_we,
    input  logic [DATA_WIDTH-1:0]   i_req_addr,
    input  logic [DATA_WIDTH-1:0]   i_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_req_be,
    output logic                    o_req_ready,
    output logic                    o_rsp_valid,
    output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
    output logic                    o_rsp_err,
    output logic                    o_stall,
    // bus side
    output logic                    o_mem_req,
    output logic                    o_mem_we,
    output logic [DATA_WIDTH-1:0]   o_mem_addr,
    output logic [DATA_WIDTH-1:0]   o_mem_wdata,
    output logic [DATA_WIDTH/8-1:0] o_mem_be,
    input  logic                    i_mem_ack,
    input  logic                    i_mem_err,
    input  logic [DATA_WIDTH-1:0]   i_mem_rdata
);

    localparam int c_BW = DATA_WIDTH / 8;
    localparam int c_CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CW-1:0] c_CNT_LAST = (TIMEOUT > 0) ? c_CW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_we;
    logic [DATA_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [c_BW-1:0]         r_be;
    logic [c_CW-1:0]         r_cnt;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;
    logic                    r_rsp_err;

    logic                    w_accept;
    logic                    w_pair;
    logic                    w_misalign;
    logic                    w_timeout;
    logic [DATA_WIDTH-1:0]   w_load_data;

    assign w_accept = (r_state == S_IDLE) && i_req_valid;

    // A halfword is any two adjacent enabled bytes; it must start on an even address.
    always_comb begin
        w_pair = 1'b0;
        for (int k = 0; k < c_BW - 1; k++) begin
            if (i_req_be == (c_BW'(3) << k)) begin
                w_pair = 1'b1;
            end
        end
        w_misalign = ((&i_req_be) && (i_req_addr[1:0] != 2'b00)) ||
                     (w_pair && i_req_addr[0]);
    end

    assign w_timeout = (TIMEOUT != 0) && (r_cnt == c_CNT_LAST);

    always_comb begin
        w_load_data = '0;
        for (int b = 0; b < c_BW; b++) begin
            w_load_data[8*b +: 8] = i_mem_rdata[8*b +: 8] & {8{r_be[b]}};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_req_valid) begin
                    w_state_nxt = w_misalign ? S_RESP : S_REQ;
                end
            end
            S_REQ: begin
                if (i_mem_ack || w_timeout) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= '0;
            r_cnt       <= '0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we    <= i_req_we;
                r_addr  <= i_req_addr;
                r_wdata <= i_req_wdata;
                r_be    <= i_req_be;
                r_cnt   <= '0;
                if (w_misalign) begin
                    r_rsp_rdata <= '0;
                    r_rsp_err   <= 1'b1;
                end
            end else if (r_state == S_REQ) begin
                // Ack wins over a timeout expiring in the same cycle.
                if (i_mem_ack) begin
                    r_rsp_rdata <= r_we ? '0 : w_load_data;
                    r_rsp_err   <= i_mem_err;
                end else if (w_timeout) begin
                    r_rsp_rdata <= '0;
                    r_rsp_err   <= 1'b1;
                end else if (TIMEOUT != 0) begin
                    r_cnt <= r_cnt + c_CW'(1);
                end
            end
        end
    end

    assign o_req_ready = (r_state == S_IDLE);
    assign o_stall     = (r_state != S_IDLE);
    assign o_rsp_valid = (r_state == S_RESP);
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;
    assign o_mem_req   = (r_state == S_REQ);
    assign o_mem_we    = r_we;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;
    assign o_mem_be    = r_be;

endmodule
`default_nettype wire

// File: tb/tb_mbscore_mem_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mbscore_mem_port
//  Purpose  : Directed vector table, reset sequence and randomized traffic
//             checked against a transaction-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mbscore_mem_port;

    localparam int c_DW      = 32;
    localparam int c_TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_req_valid, i_req_we;
    logic [c_DW-1:0]   i_req_addr, i_req_wdata;
    logic [3:0]        i_req_be;
    logic              o_req_ready, o_rsp_valid, o_rsp_err, o_stall;
    logic [c_DW-1:0]   o_rsp_rdata;
    logic              o_mem_req, o_mem_we;
    logic [c_DW-1:0]   o_mem_addr, o_mem_wdata;
    logic [3:0]        o_mem_be;
    logic              i_mem_ack, i_mem_err;
    logic [c_DW-1:0]   i_mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    mbscore_mem_port #(.DATA_WIDTH(c_DW), .TIMEOUT(c_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .i_req_we(i_req_we), .i_req_addr(i_req_addr),
        .i_req_wdata(i_req_wdata), .i_req_be(i_req_be),
        .o_req_ready(o_req_ready), .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata),
        .o_rsp_err(o_rsp_err), .o_stall(o_stall),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be),
        .i_mem_ack(i_mem_ack), .i_mem_err(i_mem_err), .i_mem_rdata(i_mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          ack_at;     // REQ cycle (1-based) carrying the ack; 0 = never
        logic [31:0] mrdata;
        logic        merr;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_nreq;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Transaction-level expectation: what the core should see for one request.
    function automatic void model(input logic we, input logic [31:0] addr, input logic [3:0] be,
                                  input int ack_at, input logic [31:0] mrd, input logic merr,
                                  output logic [31:0] rd, output logic err, output int nreq);
        bit halfword = (be == 4'h3) || (be == 4'h6) || (be == 4'hC);
        bit mis = ((be == 4'hF) && (addr[1:0] != 2'b00)) || (halfword && addr[0]);
        rd = 32'h0;
        if (mis) begin
            err = 1'b1; nreq = 0;
        end else if (ack_at >= 1 && ack_at <= c_TIMEOUT) begin
            err = merr; nreq = ack_at;
            if (!we) begin
                for (int b = 0; b < 4; b++) if (be[b]) rd[8*b +: 8] = mrd[8*b +: 8];
            end
        end else begin
            err = 1'b1; nreq = c_TIMEOUT;
        end
    endfunction

    // Entered #1 after a clock edge with the DUT idle.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input int ack_at, input logic [31:0] mrd,
                           input logic merr, output logic [31:0] got_rd, output logic got_err,
                           output int nreq, output int lat, output int nstall,
                           output int bus_bad, output int after_bad);
        bit done = 0;
        int k = 1;
        nreq = 0; lat = -1; nstall = 0; bus_bad = 0; after_bad = 0;
        got_rd = 32'hx; got_err = 1'bx;
        i_req_valid = 1'b1; i_req_we = we; i_req_addr = addr; i_req_wdata = wdata; i_req_be = be;
        i_mem_ack = 1'b0;
        @(posedge clk); #1;
        while (!done && k <= 40) begin
            if (o_mem_req) begin
                nreq++;
                if (o_mem_addr !== addr || o_mem_we !== we || o_mem_wdata !== wdata || o_mem_be !== be)
                    bus_bad++;
                if (nreq == ack_at) begin
                    i_mem_ack = 1'b1; i_mem_err = merr; i_mem_rdata = mrd;
                end else begin
                    i_mem_ack = 1'b0; i_mem_err = 1'($urandom); i_mem_rdata = $urandom;
                end
            end else begin
                i_mem_ack = 1'($urandom); i_mem_err = 1'($urandom); i_mem_rdata = $urandom;
            end
            if (o_stall) begin
                nstall++;
                i_req_valid = 1'($urandom); i_req_we = 1'($urandom);
                i_req_addr = $urandom; i_req_wdata = $urandom; i_req_be = 4'($urandom);
            end else begin
                i_req_valid = 1'b0;
            end
            if (o_rsp_valid) begin
                got_rd = o_rsp_rdata; got_err = o_rsp_err; lat = k; done = 1;
            end
            @(posedge clk); #1;
            k++;
        end
        i_req_valid = 1'b0; i_mem_ack = 1'b0;
        if (o_rsp_valid !== 1'b0 || o_req_ready !== 1'b1 || o_stall !== 1'b0 ||
            o_rsp_rdata !== got_rd || o_rsp_err !== got_err)
            after_bad = 1;
    endtask

    task automatic check_txn(input string tag, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be, input int ack_at,
                             input logic [31:0] mrd, input logic merr,
                             input logic [31:0] e_rd, input logic e_err, input int e_nreq);
        logic [31:0] rd; logic err; int nreq, lat, nstall, bus_bad, after_bad;
        run_txn(we, addr, wdata, be, ack_at, mrd, merr, rd, err, nreq, lat, nstall, bus_bad, after_bad);
        chk({tag, " rdata"},     rd,               e_rd);
        chk({tag, " err"},       32'(err),         32'(e_err));
        chk({tag, " mem_req"},   32'(nreq),        32'(e_nreq));
        chk({tag, " latency"},   32'(lat),         32'(e_nreq + 1));
        chk({tag, " stall"},     32'(nstall),      32'(e_nreq + 1));
        chk({tag, " bus"},       32'(bus_bad),     32'd0);
        chk({tag, " after"},     32'(after_bad),   32'd0);
    endtask

    initial begin
        logic [31:0] m_rd; logic m_err; int m_nreq; int rsp_seen;
        logic [3:0] be_pool[12];
        be_pool = '{4'hF, 4'h3, 4'h6, 4'hC, 4'h1, 4'h2, 4'h4, 4'h8, 4'h5, 4'hA, 4'h7, 4'h0};

        tbl[0]  = '{1'b0, 32'h100, 32'h0,        4'hF, 3,  32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0, 3};
        tbl[1]  = '{1'b1, 32'h204, 32'h12345678, 4'h3, 1,  32'hFFFFFFFF, 1'b0, 32'h0,        1'b0, 1};
        tbl[2]  = '{1'b0, 32'h102, 32'h0,        4'hF, 1,  32'h11111111, 1'b0, 32'h0,        1'b1, 0};
        tbl[3]  = '{1'b0, 32'h100, 32'h0,        4'h4, 1,  32'hAABBCCDD, 1'b0, 32'h00BB0000, 1'b0, 1};
        tbl[4]  = '{1'b0, 32'h300, 32'h0,        4'hF, 0,  32'h0,        1'b0, 32'h0,        1'b1, 16};
        tbl[5]  = '{1'b0, 32'h300, 32'h0,        4'hF, 16, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 1'b0, 16};
        tbl[6]  = '{1'b0, 32'h001, 32'h0,        4'h6, 2,  32'h12345678, 1'b0, 32'h0,        1'b1, 0};
        tbl[7]  = '{1'b0, 32'h002, 32'h0,        4'hC, 1,  32'h12345678, 1'b0, 32'h12340000, 1'b0, 1};
        tbl[8]  = '{1'b0, 32'h003, 32'h0,        4'h5, 1,  32'hA5A5A5A5, 1'b0, 32'h00A500A5, 1'b0, 1};
        tbl[9]  = '{1'b1, 32'h010, 32'hDEAD,     4'hF, 2,  32'h99,       1'b1, 32'h0,        1'b1, 2};
        tbl[10] = '{1'b0, 32'h020, 32'h0,        4'hF, 4,  32'h87654321, 1'b1, 32'h87654321, 1'b1, 4};
        tbl[11] = '{1'b1, 32'h041, 32'h55,       4'h1, 1,  32'h0,        1'b0, 32'h0,        1'b0, 1};
        tbl[12] = '{1'b0, 32'h000, 32'h0,        4'hF, 17, 32'h77777777, 1'b0, 32'h0,        1'b1, 16};

        rst_n = 1'b0;
        i_req_valid = 0; i_req_we = 0; i_req_addr = 0; i_req_wdata = 0; i_req_be = 0;
        i_mem_ack = 0; i_mem_err = 0; i_mem_rdata = 0;
        #12;
        chk("reset outputs", {o_rsp_valid, o_rsp_err, o_stall, o_mem_req, o_mem_we, o_req_ready},
            6'b000001);
        chk("reset busses", o_rsp_rdata | o_mem_addr | o_mem_wdata | 32'(o_mem_be), 32'h0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            check_txn($sformatf("vec%0d", i), tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be,
                      tbl[i].ack_at, tbl[i].mrdata, tbl[i].merr,
                      tbl[i].exp_rdata, tbl[i].exp_err, tbl[i].exp_nreq);
        end

        // Reset pulse in the middle of an outstanding access.
        i_req_valid = 1'b1; i_req_we = 1'b0; i_req_addr = 32'h400; i_req_be = 4'hF;
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        @(posedge clk); #1;
        chk("pre-reset mem_req", 32'(o_mem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async mem_req drop", 32'(o_mem_req), 32'd0);
        chk("async ready/stall", {30'd0, o_req_ready, o_stall}, 32'h2);
        chk("async rsp_rdata", o_rsp_rdata, 32'h0);
        i_mem_ack = 1'b1; i_mem_rdata = 32'h13572468;
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        rsp_seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (o_rsp_valid) rsp_seen++;
        end
        chk("no rsp after reset", 32'(rsp_seen), 32'd0);
        i_mem_ack = 1'b0;
        check_txn("post-reset", 1'b0, 32'h500, 32'h0, 4'hF, 2, 32'h2468ACE0, 1'b0,
                  32'h2468ACE0, 1'b0, 2);

        for (int t = 0; t < 150; t++) begin
            logic we; logic [31:0] addr, wdata, mrd; logic [3:0] be; int ack_at; logic merr;
            we = 1'($urandom); addr = $urandom; wdata = $urandom; mrd = $urandom;
            merr = ($urandom_range(0, 5) == 0);
            be = ($urandom_range(0, 7) == 0) ? 4'($urandom) : be_pool[$urandom_range(0, 11)];
            ack_at = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 18);
            model(we, addr, be, ack_at, mrd, merr, m_rd, m_err, m_nreq);
            check_txn($sformatf("rnd%0d", t), we, addr, wdata, be, ack_at, mrd, merr,
                      m_rd, m_err, m_nreq);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
